dual_rail_value_extract: RTL and testbench
==========================================

# dual_rail_value_extract

Receiving end of a two-phase (transition-signalling) dual-rail link: it turns rail transitions back into a clocked data word. Asynchronous rail inputs pass through a synchronizer. Per-bit transitions are detected against a stored phase reference, and a word is delivered once every bit has completed. The result is offered on a valid/ready interface, and a two-phase acknowledge toggle is returned to the link sender. The block sits at the boundary between the asynchronous link fabric and clocked logic.

## Interface
Parameters:
- ENC, "TP": encoding; only "TP" (two-phase) is supported. Any other value is an elaboration error.
- WIDTH, 1: data bits per token, ≥1.
- SYNC_STAGES, 2: synchronizer flops per rail, ≥2.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- in  in  [WIDTH-1:0][1:0]  dual-rail link. Rail [1] toggles for a 1, rail [0] toggles for a 0.
- ack  out  1  two-phase acknowledge; toggles once per consumed token.
- out_valid  out  1  out_data holds a token.
- out_ready  in  1  consumer accepts the token.
- out_data  out  WIDTH  decoded token.
- err  out  1  sticky protocol error.

## Operation
- Synchronizer: SYNC_STAGES flops on every rail; s[b][r] is the final stage.
- Phase reference ref[b][r]: registered copy of the rail levels at the last consumed token.
- Per-bit detection:
  - t1 = s[b][1]^ref[b][1], t0 = s[b][0]^ref[b][0].
  - done[b] = t1^t0.
  - bad[b] = t1&t0.
- all_done = AND of done[*]. any_bad = OR of bad[*].
- FSM states:
  - IDLE
    - any_bad → ERR.
    - Else all_done → out_data[b] ← t1, ref ← s, out_valid ← 1, go HOLD.
    - Partial completion (some bits done, others not) → stay in IDLE, no action.
  - HOLD
    - out_valid = 1. out_data and ref are frozen; rail inputs are ignored.
    - out_valid & out_ready → ack toggles, out_valid ← 0, go IDLE.
  - ERR
    - err = 1, out_valid = 0, ack frozen. Exit only by reset.
- The sender cannot issue the next token until it observes the ack toggle, so no overrun is possible in HOLD. Transitions seen during HOLD are a sender violation and are evaluated only on return to IDLE.
- After ref ← s, done[*] = 0 until new transitions arrive, so a token is never re-delivered.
- Reset values: ack 0, out_valid 0, out_data 0, err 0, ref all 0, synchronizer all 0, state IDLE. The link sender must also return its rails to 0 under reset.
- Reset during HOLD discards the pending token without an ack toggle.

## Timing
- A rail change first captured at edge k appears on s at edge k+SYNC_STAGES-1.
- out_valid and out_data register at the next edge, k+SYNC_STAGES, provided that bit completes the word.
- Word latency is set by the last-arriving bit; bit skew adds directly.
- Handshake completes at edge e where out_valid & out_ready; ack and out_valid=0 are visible after e.
- out_ready high in advance: handshake occurs on the first out_valid cycle.
- ack back to next-token out_valid: SYNC_STAGES+1 cycles minimum plus sender and link delay.
- Maximum throughput: one token per (2 + SYNC_STAGES + external round trip) cycles.
- err asserts at the edge after any_bad is seen in IDLE and holds until reset.
- out_valid stays asserted and out_data stays stable for as long as out_ready is low.

## Test plan
- Reset: hold rst=0 with random rail activity → ack=0, out_valid=0, out_data=0, err=0. Release, then rails static → no out_valid.
- Single token, WIDTH=4, SYNC_STAGES=2:
  - Toggle rail[1] of bits 3,1 and rail[0] of bits 2,0 at once → out_valid=1 with out_data=4'hA, exactly 2 cycles after capture.
  - out_ready=1 → ack 0→1, out_valid drops the next cycle.
- Backpressure: token 4'h3 with out_ready=0 for 10 cycles → out_valid=1, out_data=4'h3 stable, ack unchanged. Raise out_ready → single ack toggle.
- Skew and phase tracking:
  - Deliver 4'h5 one bit per cycle → no out_valid until the fourth bit arrives, then out_data=4'h5.
  - Next token 4'h5 reuses the toggled rails → ref tracking produces 4'h5 again, ack returns to its previous level.
- Error: toggle both rails of bit 2 → err=1 and stays 1. No out_valid, ack frozen, even with further valid tokens. Reset clears err.
- Reset mid-HOLD: token 4'hF pending with out_ready=0, pulse rst → out_valid=0, ack=0, ref=0. A fresh token from a reset sender is then decoded correctly.

Source files
------------

// File: rtl/dual_rail_value_extract.sv
// rtl/dual_rail_value_extract.sv - two-phase dual-rail link receiver with valid/ready output and ack toggle
module dual_rail_value_extract #(
    parameter           ENC         = "TP",
    parameter int       WIDTH       = 1,
    parameter int       SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0][1:0]  in,
    output logic                   ack,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   err
);

    generate
        if (ENC != "TP") begin : g_bad_enc
            $error("dual_rail_value_extract: only two-phase (TP) encoding is supported");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("dual_rail_value_extract: WIDTH must be at least 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("dual_rail_value_extract: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                              state;
    logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
    logic [WIDTH-1:0][1:0]               s;
    logic [WIDTH-1:0][1:0]               phase_ref;
    logic [WIDTH-1:0]                    t1;
    logic [WIDTH-1:0]                    t0;
    logic [WIDTH-1:0]                    done;
    logic [WIDTH-1:0]                    bad;
    logic                                all_done;
    logic                                any_bad;

    // Rails are asynchronous to clk; every rail gets its own flop chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A bit is complete when exactly one of its rails differs from the reference.
    always_comb begin
        t1   = '0;
        t0   = '0;
        done = '0;
        bad  = '0;
        for (int b = 0; b < WIDTH; b++) begin
            t1[b]   = s[b][1] ^ phase_ref[b][1];
            t0[b]   = s[b][0] ^ phase_ref[b][0];
            done[b] = t1[b] ^ t0[b];
            bad[b]  = t1[b] & t0[b];
        end
    end

    assign all_done = &done;
    assign any_bad  = |bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            phase_ref <= '0;
            ack       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_bad) begin
                        err       <= 1'b1;
                        out_valid <= 1'b0;
                        state     <= ST_ERR;
                    end else if (all_done) begin
                        out_data  <= t1;
                        phase_ref <= s;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Rails are not examined here; late transitions are judged back in IDLE.
                    if (out_ready) begin
                        ack       <= ~ack;
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    err       <= 1'b1;
                    out_valid <= 1'b0;
                end
                default: begin
                    state <= ST_ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_rail_value_extract.sv
// tb/tb_dual_rail_value_extract.sv - directed and randomized checks of dual_rail_value_extract
module tb_dual_rail_value_extract;

    localparam int W = 4;

    logic               clk;
    logic               rst;
    logic [W-1:0][1:0]  rails;
    logic               ack;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic               err;

    int                 errors;
    int                 checks;
    logic               exp_ack;

    dual_rail_value_extract #(
        .ENC("TP"),
        .WIDTH(W),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(rails),
        .ack(ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sender model: a 1 toggles rail[1], a 0 toggles rail[0].
    task automatic send_bit(input int b, input logic v);
        if (v) rails[b][1] = ~rails[b][1];
        else   rails[b][0] = ~rails[b][0];
    endtask

    task automatic send_word(input logic [W-1:0] v);
        for (int b = 0; b < W; b++) send_bit(b, v[b]);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check({tag, "_ack"}, {31'd0, ack}, {31'd0, exp_ack});
        check({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        rails = '0;
        tick();
        tick();
        rst   = 1'b1;
        exp_ack = 1'b0;
        tick();
    endtask

    initial begin
        logic [W-1:0] tok;
        logic         prev_ack;
        int           dly;

        errors    = 0;
        checks    = 0;
        exp_ack   = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b0;
        rails     = '0;

        // Reset with rail noise
        for (int i = 0; i < 6; i++) begin
            rails = 8'($urandom);
            tick();
        end
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {28'd0, out_data}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rails = '0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_static_valid", {31'd0, out_valid}, 32'd0);

        // Single token 4'hA with exact latency
        send_word(4'hA);
        tick();
        check("lat_k", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_k1", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_k2", {31'd0, out_valid}, 32'd1);
        check("tokA_data", {28'd0, out_data}, 32'hA);
        handshake("tokA");

        // Backpressure with 4'h3
        send_word(4'h3);
        wait_valid("bp_valid", 10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data", {28'd0, out_data}, 32'h3);
            check("bp_hold_ack", {31'd0, ack}, {31'd0, exp_ack});
        end
        handshake("bp");
        for (int i = 0; i < 3; i++) tick();
        check("bp_single_toggle", {31'd0, ack}, {31'd0, exp_ack});

        // Skewed 4'h5, one bit per cycle
        prev_ack = exp_ack;
        for (int b = 0; b < W; b++) begin
            send_bit(b, 1'(4'h5 >> b));
            tick();
            check("skew_no_early", {31'd0, out_valid}, 32'd0);
        end
        wait_valid("skew_valid", 10);
        check("skew_data", {28'd0, out_data}, 32'h5);
        handshake("skew");

        // Same token again reuses toggled rails
        send_word(4'h5);
        wait_valid("rep_valid", 10);
        check("rep_data", {28'd0, out_data}, 32'h5);
        handshake("rep");
        check("rep_ack_level", {31'd0, ack}, {31'd0, prev_ack});

        // Randomized tokens with random skew and backpressure
        for (int t = 0; t < 24; t++) begin
            tok = 4'($urandom);
            for (int b = 0; b < W; b++) begin
                send_bit(b, tok[b]);
                if ($urandom_range(0, 2) == 0) tick();
            end
            wait_valid("rnd_valid", 16);
            check("rnd_data", {28'd0, out_data}, {28'd0, tok});
            dly = $urandom_range(0, 3);
            for (int i = 0; i < dly; i++) begin
                tick();
                check("rnd_stall_data", {28'd0, out_data}, {28'd0, tok});
            end
            handshake("rnd");
        end

        // Protocol error: both rails of bit 2
        out_ready = 1'b1;
        rails[2] = ~rails[2];
        for (int i = 0; i < 4; i++) tick();
        check("err_set", {31'd0, err}, 32'd1);
        check("err_no_valid", {31'd0, out_valid}, 32'd0);
        send_word(4'h6);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("err_sticky", {31'd0, err}, 32'd1);
            check("err_valid_low", {31'd0, out_valid}, 32'd0);
        end
        check("err_ack_frozen", {31'd0, ack}, {31'd0, exp_ack});
        out_ready = 1'b0;
        do_reset();
        check("err_cleared", {31'd0, err}, 32'd0);
        check("err_rst_ack", {31'd0, ack}, 32'd0);
        send_word(4'h9);
        wait_valid("post_err_valid", 10);
        check("post_err_data", {28'd0, out_data}, 32'h9);
        handshake("post_err");

        // Reset while a token is pending
        send_word(4'hF);
        wait_valid("hold_valid", 10);
        do_reset();
        check("midhold_valid", {31'd0, out_valid}, 32'd0);
        check("midhold_ack", {31'd0, ack}, 32'd0);
        check("midhold_data", {28'd0, out_data}, 32'd0);
        send_word(4'hA);
        wait_valid("fresh_valid", 10);
        check("fresh_data", {28'd0, out_data}, 32'hA);
        handshake("fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
